// File: rtl/lvds_pulse_tx_if.sv
// lvds_pulse_tx_if: control and output bundle of the pulse transmitter.
// master drives burst control, slave is the transmitter.
interface lvds_pulse_tx_if #(
  parameter int NBINS = 8,
  parameter int PW    = $clog2(NBINS)
);
  logic             start;
  logic             abort;
  logic [PW-1:0]    phaseoffset;
  logic [PW:0]      pulsewidth;
  logic [7:0]       period;
  logic [7:0]       npulses;
  logic             randphase;
  logic             clrcount;
  logic [NBINS-1:0] lvds_tx;
  logic             busy;
  logic             done;
  logic [15:0]      pulsecount;

  modport master (
    output start, abort, phaseoffset, pulsewidth,
    output period, npulses, randphase, clrcount,
    input  lvds_tx, busy, done, pulsecount
  );

  modport slave (
    input  start, abort, phaseoffset, pulsewidth,
    input  period, npulses, randphase, clrcount,
    output lvds_tx, busy, done, pulsecount
  );
endinterface

// File: rtl/lvds_pulse_tx.sv
// lvds_pulse_tx: fine-bin pulse burst generator for an LVDS serializer.
// Optional LFSR random phase: define PULSE_TX_PRBS_EN.
module lvds_pulse_tx #(
  parameter int NBINS = 8,
  parameter int PW    = $clog2(NBINS)
) (
  input  logic clkin,
  input  logic rst,
  lvds_pulse_tx_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FIRE = 2'd1,
    GAP  = 2'd2,
    TAIL = 2'd3
  } state_t;

  localparam logic [PW:0] WMAX = (PW+1)'(NBINS);

  state_t             state_q, state_d;
  logic [7:0]         cnt_q, cnt_d;
  logic [7:0]         rem_q, rem_d;
  logic [7:0]         per_q, per_d;
  logic [PW-1:0]      ph_q, ph_d;
  logic [PW:0]        wid_q, wid_d;
  logic [NBINS-1:0]   spill_q, spill_d;
  logic [NBINS-1:0]   lvds_q, lvds_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [15:0]        pcnt_q, pcnt_d;

  logic               go;
  logic               fire_ok;
  logic [PW-1:0]      ph_now;
  logic [2*NBINS-1:0] ones;
  logic [2*NBINS-1:0] mask;

  assign go      = (state_q == IDLE) && bus.start && !bus.abort;
  assign fire_ok = (state_q == FIRE) && !bus.abort;

`ifdef PULSE_TX_PRBS_EN
  logic [15:0] lfsr_q, lfsr_d;
  logic        rnd_q, rnd_d;
  logic        fb;

  assign fb     = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];
  assign ph_now = rnd_q ? lfsr_q[PW-1:0] : ph_q;

  // LFSR steps once per emitted head; phase mode latched at start
  always_comb begin
    lfsr_d = lfsr_q;
    rnd_d  = rnd_q;
    if (go)      rnd_d  = bus.randphase;
    if (fire_ok) lfsr_d = {lfsr_q[14:0], fb};
  end

  // LFSR and phase-mode registers
  always_ff @(posedge clkin or posedge rst) begin
    if (rst) begin
      lfsr_q <= 16'hACE1;
      rnd_q  <= 1'b0;
    end else begin
      lfsr_q <= lfsr_d;
      rnd_q  <= rnd_d;
    end
  end
`else
  logic unused_rand;

  assign unused_rand = bus.randphase;
  assign ph_now      = ph_q;
`endif

  // head occupies the low half, spill into next word the high half
  always_comb begin
    ones = ~({(2*NBINS){1'b1}} << wid_q);
    mask = ones << ph_now;
  end

  // next state, burst counters and output words
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    per_d   = per_q;
    ph_d    = ph_q;
    wid_d   = wid_q;
    spill_d = '0;
    lvds_d  = '0;
    done_d  = 1'b0;
    pcnt_d  = pcnt_q;

    unique case (state_q)
      IDLE: begin
        if (go) begin
          ph_d    = bus.phaseoffset;
          rem_d   = bus.npulses;
          per_d   = (bus.period < 8'd2) ? 8'd2 : bus.period;
          if (bus.pulsewidth == '0)
            wid_d = (PW+1)'(1);
          else if (bus.pulsewidth > WMAX)
            wid_d = WMAX;
          else
            wid_d = bus.pulsewidth;
          cnt_d   = 8'd0;
          state_d = GAP;
        end
      end
      FIRE: begin
        lvds_d  = mask[NBINS-1:0];
        spill_d = mask[2*NBINS-1:NBINS];
        pcnt_d  = pcnt_q + 16'd1;
        if (rem_q == 8'd1) begin
          state_d = TAIL;
        end else begin
          state_d = GAP;
          cnt_d   = per_q - 8'd2;
          if (rem_q != 8'd0) rem_d = rem_q - 8'd1;
        end
      end
      GAP: begin
        lvds_d = spill_q;
        if (cnt_q == 8'd0) state_d = FIRE;
        else               cnt_d   = cnt_q - 8'd1;
      end
      TAIL: begin
        lvds_d  = spill_q;
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (bus.abort && state_q != IDLE) begin
      state_d = IDLE;
      lvds_d  = '0;
      spill_d = '0;
      done_d  = 1'b0;
      pcnt_d  = pcnt_q;
    end

    if (bus.clrcount) pcnt_d = 16'd0;

    busy_d = (state_d != IDLE);
  end

  // state, latched config and registered outputs
  always_ff @(posedge clkin or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      per_q   <= '0;
      ph_q    <= '0;
      wid_q   <= '0;
      spill_q <= '0;
      lvds_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      per_q   <= per_d;
      ph_q    <= ph_d;
      wid_q   <= wid_d;
      spill_q <= spill_d;
      lvds_q  <= lvds_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pcnt_q  <= pcnt_d;
    end
  end

  assign bus.lvds_tx    = lvds_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.pulsecount = pcnt_q;

endmodule

// File: tb/tb_lvds_pulse_tx.sv
// tb_lvds_pulse_tx: scoreboard bench for lvds_pulse_tx (NBINS=8).
// Honours PULSE_TX_PRBS_EN for the random-phase expectation.
module tb_lvds_pulse_tx;

  logic clk = 1'b0;
  logic rst = 1'b1;

  lvds_pulse_tx_if #(.NBINS(8)) bus ();

  lvds_pulse_tx #(.NBINS(8)) dut (
    .clkin (clk),
    .rst   (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [9:0]  exp_q[$];
  logic [15:0] lfsr_m = 16'hACE1;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [15:0] lfsr_nx(logic [15:0] l);
    return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
  endfunction

  function automatic logic [15:0] mask2(int p, int w);
    logic [15:0] m;
    for (int i = 0; i < 16; i++) m[i] = (i >= p) && (i < p + w);
    return m;
  endfunction

  // expected {busy,done,lvds} per cycle, k=0 is the start-sampling edge
  task automatic push_burst(int p, int w, int per, int n, int ak, bit rnd);
    int wc, pc, np, kd, last;
    int ph[$];
    logic [15:0] m;
    logic [7:0]  lv;
    logic        b, d;
    wc   = (w == 0) ? 1 : (w > 8) ? 8 : w;
    pc   = (per < 2) ? 2 : per;
    kd   = (n != 0) ? 3 + (n - 1) * pc : -1;
    last = (n != 0) ? kd : ak + 1;
    np   = (n != 0) ? n : last / pc + 2;
    for (int j = 0; j < np; j++) begin
`ifdef PULSE_TX_PRBS_EN
      ph.push_back(rnd ? int'(lfsr_m[2:0]) : p);
`else
      ph.push_back(p);
`endif
      lfsr_m = lfsr_nx(lfsr_m);
    end
    for (int k = 0; k <= last; k++) begin
      b  = (n != 0) ? (k < kd) : 1'b1;
      d  = (k == kd);
      lv = '0;
      if (k >= 2 && (k - 2) % pc == 0 && (k - 2) / pc < np) begin
        m  = mask2(ph[(k - 2) / pc], wc);
        lv = m[7:0];
      end else if (k >= 3 && (k - 3) % pc == 0 && (k - 3) / pc < np) begin
        m  = mask2(ph[(k - 3) / pc], wc);
        lv = m[15:8];
      end
      if (ak >= 0 && k >= ak) begin
        b = 1'b0; d = 1'b0; lv = '0;
      end
      exp_q.push_back({b, d, lv});
    end
  endtask

  // compare DUT output against the scoreboard each cycle
  always @(posedge clk) begin
    #2;
    if (exp_q.size() > 0)
      chk("trace", {bus.busy, bus.done, bus.lvds_tx}, exp_q.pop_front());
  end

  // drive start at a negedge; returns one cycle later with config scrambled
  task automatic launch(int p, int w, int per, int n, int ak, bit rnd);
    @(negedge clk);
    bus.phaseoffset = 3'(p);
    bus.pulsewidth  = 4'(w);
    bus.period      = 8'(per);
    bus.npulses     = 8'(n);
    bus.randphase   = rnd;
    bus.start       = 1'b1;
    push_burst(p, w, per, n, ak, rnd);
    @(negedge clk);
    bus.start       = 1'b0;
    bus.phaseoffset = 3'($urandom);
    bus.pulsewidth  = 4'($urandom);
    bus.period      = 8'($urandom_range(2, 9));
    bus.npulses     = 8'($urandom_range(1, 5));
    bus.randphase   = 1'($urandom);
  endtask

  task automatic drain();
    for (int i = 0; i < 300 && exp_q.size() > 0; i++) @(negedge clk);
    chk("drain", exp_q.size(), 0);
    exp_q.delete();
    @(negedge clk);
  endtask

  initial begin
    bus.start = 0; bus.abort = 0; bus.clrcount = 0; bus.randphase = 0;
    bus.phaseoffset = 0; bus.pulsewidth = 0; bus.period = 0; bus.npulses = 0;
    repeat (2) @(negedge clk);
    chk("rst_lvds", bus.lvds_tx, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_cnt", bus.pulsecount, 0);
    rst = 1'b0;
    @(negedge clk);

    launch(2, 3, 4, 3, -1, 0);
    drain();
    chk("cnt_basic", bus.pulsecount, 3);

    launch(6, 4, 2, 2, -1, 0);
    drain();
    launch(3, 0, 3, 1, -1, 0);
    drain();
    launch(0, 15, 0, 2, -1, 0);
    drain();
    chk("cnt_more", bus.pulsecount, 8);

    @(negedge clk);
    bus.start = 1; bus.abort = 1;
    @(negedge clk);
    bus.start = 0; bus.abort = 0;
    chk("start_abort_idle", bus.busy, 0);

    bus.clrcount = 1;
    @(negedge clk);
    bus.clrcount = 0;
    chk("clr_idle", bus.pulsecount, 0);

    launch(1, 2, 5, 0, 34, 0);
    repeat (8) @(negedge clk);
    @(negedge clk);
    bus.start = 1;
    @(negedge clk);
    bus.start = 0;
    repeat (22) @(negedge clk);
    @(negedge clk);
    bus.abort = 1;
    @(negedge clk);
    bus.abort = 0;
    drain();
    chk("cnt_abort", bus.pulsecount, 7);
    chk("abort_done", bus.done, 0);

    launch(0, 2, 4, 3, -1, 0);
    @(negedge clk);
    bus.clrcount = 1;
    @(negedge clk);
    chk("clr_on_fire", bus.pulsecount, 0);
    bus.clrcount = 0;
    drain();
    chk("cnt_after_clr", bus.pulsecount, 2);

    @(negedge clk);
    force dut.pcnt_q = 16'hFFFE;
    #1 release dut.pcnt_q;
    launch(4, 2, 2, 2, -1, 0);
    drain();
    chk("cnt_wrap", bus.pulsecount, 0);

    launch(6, 4, 8, 2, -1, 0);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    chk("pre_rst_lvds", bus.lvds_tx, 8'h03);
    rst = 1'b1;
    exp_q.delete();
    #1;
    chk("arst_lvds", bus.lvds_tx, 0);
    chk("arst_busy", bus.busy, 0);
    chk("arst_cnt", bus.pulsecount, 0);
    @(negedge clk);
    rst = 1'b0;
    lfsr_m = 16'hACE1;
    @(negedge clk);

    launch(5, 1, 2, 2, -1, 1);
    drain();
    chk("cnt_prbs", bus.pulsecount, 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
